fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the 8-bit PC and the 16-bit instruction register (IR).
- Fetches one instruction per request over a req/ack instruction-memory port.
- Presents IR to decode with a valid/ready handshake, and takes decode's jump decision (PC_select, jump_addr) to choose the next PC.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
// Owns the 8-bit PC and the 16-bit instruction register. It issues one
// request at a time on a req/ack memory port and presents each fetched
// word to decode with a valid/ready handshake. Decode's jump decision
// selects the next PC.
// Optional feature: define FETCH_HALT_EN to build halt-opcode support
// (instr[3:0] == 4'b1111 stops fetching until reset).
module fetch_unit #(
    parameter logic [7:0] RESET_PC       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 16     // legal range 2..255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PC_select,
    input  logic [7:0]  jump_addr,
    output logic [7:0]  pc,
    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_ERR
`ifdef FETCH_HALT_EN
        , S_HALT
`endif
    } state_e;

    // Value the wait counter holds during the last ack-less cycle that is
    // still allowed; one more miss means TIMEOUT_CYCLES have elapsed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;

    // State register: FSM state, PC, IR and ack-timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            cnt_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: fetch sequencing, IR capture, PC update, timeout.
    always_comb begin
        // NOTE: hold-current defaults on every path so no latches are inferred.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_BOOT: begin
                cnt_d   = 8'd0;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // An ack arriving in the final allowed cycle still wins.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                // instr_valid is implied in HOLD, so ready alone means consume.
                if (instr_ready) begin
                    state_d = S_FETCH;
                    pc_d    = PC_select ? jump_addr : pc_q + 8'd1;
`ifdef FETCH_HALT_EN
                    // Halt is decided ahead of the jump: a halt opcode never jumps.
                    if (instr_q[3:0] == 4'b1111) begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
`endif
                end
            end

            default: begin
                // ERR (and HALT when built) are terminal until reset.
            end
        endcase
    end

    // Output decode: every handshake/status output follows the registered state.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: imem_req    = 1'b1;
            S_HOLD:  instr_valid = 1'b1;
            S_ERR:   fetch_err   = 1'b1;
`ifdef FETCH_HALT_EN
            S_HALT:  halted      = 1'b1;
`endif
            default: begin
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a scoreboard of
// {address, instruction word} pairs pushed when memory acks and popped
// when decode consumes the instruction register.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        PC_select = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [7:0]  pc;
    logic        fetch_err;
    logic        halted;

    int          total = 0;
    int          bad = 0;
    logic [23:0] sb_q[$];
    bit          hold_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PC_select   (PC_select),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .fetch_err   (fetch_err),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait for a request, verify its address, ack after lat cycles and log
    // the expected IR contents in the scoreboard.
    task automatic fetch(input logic [7:0] exp_addr, input logic [15:0] data, input int lat);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 1);
        check("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        check("fetch_novalid", 32'(instr_valid), 0);
        repeat (lat) @(negedge clk);
        check("req_held", 32'(imem_req), 1);
        check("no_err", 32'(fetch_err), 0);
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb_q.push_back({exp_addr, data});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
    endtask

    // Compare the presented IR against the scoreboard, then consume it.
    task automatic consume(input logic sel, input logic [7:0] ja);
        logic [23:0] exp;
        check("valid", 32'(instr_valid), 1);
        check("sb_depth", 32'(sb_q.size()), 1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 24'h0;
        check("instr", 32'(instr), 32'(exp[15:0]));
        check("pc", 32'(pc), 32'(exp[23:16]));
        instr_ready = 1'b1;
        PC_select   = sel;
        jump_addr   = ja;
        @(negedge clk);
        instr_ready = hold_ready;
        PC_select   = 1'b0;
        jump_addr   = 8'($urandom);
        check("valid_clr", 32'(instr_valid), 0);
    endtask

    // Pulse reset and return at the cycle the first request is visible.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_req", 32'(imem_req), 1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_err", 32'(fetch_err), 0);
        check("rst_halted", 32'(halted), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_rise", 32'(imem_req), 1);
        check("addr0", 32'(imem_addr), 0);

        // First fetch, then sequential flow with ready held high, then a jump.
        fetch(8'h00, 16'h0123, 2);
        consume(1'b0, 8'h00);
        hold_ready  = 1'b1;
        instr_ready = 1'b1;
        fetch(8'h01, 16'h2340, 2);
        consume(1'b0, 8'h00);
        fetch(8'h02, 16'h3450, 3);
        consume(1'b0, 8'h00);
        fetch(8'h03, 16'h4569, 1);
        consume(1'b1, 8'h5A);
        hold_ready  = 1'b0;
        instr_ready = 1'b0;

        // Jump target fetched; stall 5 cycles with a stray ack and ignored jump inputs.
        fetch(8'h5A, 16'h1110, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_instr", 32'(instr), 32'h1110);
            check("stall_pc", 32'(pc), 32'h5A);
            check("stall_req", 32'(imem_req), 0);
            check("stall_valid", 32'(instr_valid), 1);
            imem_ack   = (i == 2);
            imem_rdata = 16'hDEAD;
            PC_select  = 1'b1;
            jump_addr  = 8'h33;
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        PC_select = 1'b0;
        consume(1'b0, 8'h00);

        // PC wrap 8'hFF -> 8'h00, then the 4'b1111 opcode.
        fetch(8'h5B, 16'h2000, 1);
        consume(1'b1, 8'hFF);
        fetch(8'hFF, 16'h2001, 2);
        consume(1'b0, 8'h00);
        fetch(8'h00, 16'h000F, 1);
        consume(1'b1, 8'h77);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 5; i++) begin
            check("halt_flag", 32'(halted), 1);
            check("halt_req", 32'(imem_req), 0);
            check("halt_pc", 32'(pc), 0);
            @(negedge clk);
        end
`else
        check("nohalt_flag", 32'(halted), 0);
        fetch(8'h77, 16'h0042, 1);
        consume(1'b0, 8'h00);
`endif

        // Ack in the final allowed cycle wins over the timeout.
        do_reset();
        fetch(8'h00, 16'h5555, 15);
        check("ackwin_err", 32'(fetch_err), 0);
        consume(1'b0, 8'h00);

        // Timeout: 16 cycles without ack.
        check("to_req0", 32'(imem_req), 1);
        repeat (15) @(negedge clk);
        check("to_req15", 32'(imem_req), 1);
        check("to_err15", 32'(fetch_err), 0);
        @(negedge clk);
        check("to_err", 32'(fetch_err), 1);
        check("to_req", 32'(imem_req), 0);
        check("to_valid", 32'(instr_valid), 0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(fetch_err), 1);
        check("err_req", 32'(imem_req), 0);
        check("err_valid", 32'(instr_valid), 0);
        check("err_instr", 32'(instr), 32'h5555);
        check("err_pc", 32'(pc), 32'h01);

        // Asynchronous reset mid-fetch; the abandoned request's ack is ignored.
        do_reset();
        fetch(8'h00, 16'h6666, 1);
        consume(1'b0, 8'h00);
        check("mid_req", 32'(imem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 0);
        check("arst_pc", 32'(pc), 0);
        check("arst_instr", 32'(instr), 0);
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_err", 32'(fetch_err), 0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_instr", 32'(instr), 0);
        check("late_ack_valid", 32'(instr_valid), 0);
        check("late_ack_req", 32'(imem_req), 1);
        fetch(8'h00, 16'h7777, 2);
        consume(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
